// File: rtl/tile_pkg.sv
// tile_pkg: shared types and constants for the 5x5 tile-sort puzzle controller.
//   - FSM state encoding and button direction encoding
//   - grid geometry constants and button index map
//   - step_coord(): one-cell selector step with edge handling
// Optional build macro: SEL_WRAP_EN (selector and swap neighbours wrap modulo GRID).
package tile_pkg;

   localparam int         GRID     = 5;
   localparam int         TILE_CNT = GRID * GRID;
   localparam logic [2:0] GRID_MAX = 3'(GRID - 1);
   localparam logic [4:0] LAST_ADDR = 5'(TILE_CNT - 1);
   localparam logic [4:0] SCAN_END  = 5'(TILE_CNT);

   // Bit positions of the buttons in the packed press vector.
   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_CENTER = 4;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      RD_A  = 3'd2,
      RD_B  = 3'd3,
      WR_A  = 3'd4,
      WR_B  = 3'd5,
      CHECK = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      DIR_NONE  = 3'd0,
      DIR_UP    = 3'd1,
      DIR_DOWN  = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_RIGHT = 3'd4
   } dir_e;

   // Returns {off_grid, new_pos}. When a step would leave the grid the position
   // is held and off_grid is raised, unless wrapping is built in.
   function automatic logic [3:0] step_coord(input logic [2:0] pos,
                                             input logic       inc,
                                             input logic       dec);
      logic [3:0] res;
      res = {1'b0, pos};
      if (inc) begin
         if (pos == GRID_MAX) begin
`ifdef SEL_WRAP_EN
            res = {1'b0, 3'd0};
`else
            res = {1'b1, pos};
`endif
         end else begin
            res = {1'b0, pos + 3'd1};
         end
      end else if (dec) begin
         if (pos == 3'd0) begin
`ifdef SEL_WRAP_EN
            res = {1'b0, GRID_MAX};
`else
            res = {1'b1, pos};
`endif
         end else begin
            res = {1'b0, pos - 3'd1};
         end
      end else begin
         res = {1'b0, pos};
      end
      return res;
   endfunction

endpackage

// File: rtl/tile_move_ctrl_btn_debounce.sv
// btn_debounce: one board button conditioner.
//   clk, rst  : system clock, synchronous active-high reset
//   btn       : raw asynchronous button level, active-high
//   press     : single-cycle pulse on each debounced rising edge (registered)
// The debounced level flips only after the synchronised input has differed
// from it for more than DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic        sync1_r;
   logic        sync2_r;
   logic        level_r;
   logic        press_r;
   logic [19:0] cnt_r;

   // Synchroniser, stability counter, debounced level and rising-edge pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= 20'd0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (sync2_r == level_r) begin
            cnt_r <= 20'd0;
         end else if (cnt_r == DEBOUNCE_CYCLES) begin
            level_r <= sync2_r;
            cnt_r   <= 20'd0;
            press_r <= sync2_r;
         end else begin
            cnt_r <= cnt_r + 20'd1;
         end
      end
   end

   assign press = press_r;

endmodule

// File: rtl/tile_move_ctrl.sv
// tile_move_ctrl: game controller for the 5x5 tile-sort puzzle.
//   clk, rst            : system clock, synchronous active-high reset
//   btn_up..btn_center  : raw asynchronous buttons, active-high
//   sel_row, sel_col    : selector position 0..4
//   grabbed             : selected tile held for a swap
//   ram_addr/we/wdata   : single-port tile RAM write/read port
//   ram_rdata           : RAM read data, valid one cycle after ram_addr
//   busy                : FSM not in IDLE
//   solved              : last scan found every address holding its own index
//   move_count          : completed swaps, saturating
// Optional build macro: SEL_WRAP_EN (wrap selector/neighbours instead of clamp/cancel).
// All outputs except ram_wdata are registered; every register holds the value
// belonging to the state it is in. ram_wdata forwards ram_rdata during WR_A so
// B's tile, arriving that cycle, is written to A without an extra cycle.
module tile_move_ctrl
   import tile_pkg::*;
#(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter int          MOVE_W          = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_center,
   output logic [2:0]        sel_row,
   output logic [2:0]        sel_col,
   output logic              grabbed,
   output logic [4:0]        ram_addr,
   output logic              ram_we,
   output logic [4:0]        ram_wdata,
   input  logic [4:0]        ram_rdata,
   output logic              busy,
   output logic              solved,
   output logic [MOVE_W-1:0] move_count
);

   localparam logic [MOVE_W-1:0] MC_ONE = {{(MOVE_W-1){1'b0}}, 1'b1};
   localparam logic [MOVE_W-1:0] MC_MAX = {MOVE_W{1'b1}};

   // row*5+col as (row<<2)+row+col.
   function automatic logic [4:0] cell_addr(input logic [2:0] row, input logic [2:0] col);
      return {row, 2'b00} + {2'b00, row} + {2'b00, col};
   endfunction

   logic [4:0] btn_raw_s;
   logic [4:0] press_s;

   assign btn_raw_s = {btn_center, btn_right, btn_left, btn_down, btn_up};

   for (genvar i = 0; i < 5; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn_raw_s[i]),
         .press (press_s[i])
      );
   end

   state_e            state_r, state_nxt;
   logic [4:0]        cnt_r, cnt_nxt;       // INIT: next index to write; CHECK: scan cycle
   logic              ok_r, ok_nxt;         // all compares so far matched
   logic [2:0]        sel_row_r, sel_row_nxt;
   logic [2:0]        sel_col_r, sel_col_nxt;
   logic [2:0]        tgt_row_r, tgt_row_nxt;
   logic [2:0]        tgt_col_r, tgt_col_nxt;
   logic              grabbed_r, grabbed_nxt;
   logic [4:0]        ram_addr_r, ram_addr_nxt;
   logic              ram_we_r, ram_we_nxt;
   logic [4:0]        wdata_r, wdata_nxt;   // also holds A's tile during a swap
   logic              wr_pass_r, wr_pass_nxt;
   logic              busy_r;
   logic              solved_r, solved_nxt;
   logic [MOVE_W-1:0] mc_r, mc_nxt;

   logic              center_s;
   dir_e              dir_s;
   logic [3:0]        row_step_s;
   logic [3:0]        col_step_s;
   logic              off_grid_s;
   logic              match_s;
   logic              ok_upd_s;

   // Press arbitration: center > up > down > left > right.
   always_comb begin
      center_s = 1'b0;
      dir_s    = DIR_NONE;
      if (press_s[BTN_CENTER]) begin
         center_s = 1'b1;
      end else if (press_s[BTN_UP]) begin
         dir_s = DIR_UP;
      end else if (press_s[BTN_DOWN]) begin
         dir_s = DIR_DOWN;
      end else if (press_s[BTN_LEFT]) begin
         dir_s = DIR_LEFT;
      end else if (press_s[BTN_RIGHT]) begin
         dir_s = DIR_RIGHT;
      end else begin
         dir_s = DIR_NONE;
      end
   end

   // Neighbour cell and scan compare helpers.
   always_comb begin
      row_step_s = step_coord(sel_row_r, dir_s == DIR_DOWN,  dir_s == DIR_UP);
      col_step_s = step_coord(sel_col_r, dir_s == DIR_RIGHT, dir_s == DIR_LEFT);
      off_grid_s = row_step_s[3] | col_step_s[3];
      match_s    = (ram_rdata == (cnt_r - 5'd1));
      ok_upd_s   = ok_r & ((cnt_r == 5'd0) | match_s);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state_r;
      cnt_nxt      = cnt_r;
      ok_nxt       = ok_r;
      sel_row_nxt  = sel_row_r;
      sel_col_nxt  = sel_col_r;
      tgt_row_nxt  = tgt_row_r;
      tgt_col_nxt  = tgt_col_r;
      grabbed_nxt  = grabbed_r;
      ram_addr_nxt = ram_addr_r;
      ram_we_nxt   = 1'b0;
      wdata_nxt    = wdata_r;
      wr_pass_nxt  = 1'b0;
      solved_nxt   = solved_r;
      mc_nxt       = mc_r;
      case (state_r)
         INIT: begin
            if (cnt_r == SCAN_END) begin
               state_nxt    = CHECK;
               ram_addr_nxt = 5'd0;
               cnt_nxt      = 5'd0;
               ok_nxt       = 1'b1;
            end else begin
               ram_we_nxt   = 1'b1;
               ram_addr_nxt = cnt_r;
               wdata_nxt    = cnt_r;
               cnt_nxt      = cnt_r + 5'd1;
            end
         end
         IDLE: begin
            if (center_s) begin
               grabbed_nxt = ~grabbed_r;
            end else if (dir_s != DIR_NONE) begin
               if (!grabbed_r) begin
                  sel_row_nxt = row_step_s[2:0];
                  sel_col_nxt = col_step_s[2:0];
               end else if (off_grid_s) begin
                  grabbed_nxt = 1'b0;
               end else begin
                  tgt_row_nxt  = row_step_s[2:0];
                  tgt_col_nxt  = col_step_s[2:0];
                  state_nxt    = RD_A;
                  ram_addr_nxt = cell_addr(sel_row_r, sel_col_r);
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         RD_A: begin
            state_nxt    = RD_B;
            ram_addr_nxt = cell_addr(tgt_row_r, tgt_col_r);
         end
         RD_B: begin
            // A's tile arrives now; keep it in the write-data register for WR_B.
            wdata_nxt    = ram_rdata;
            state_nxt    = WR_A;
            ram_addr_nxt = cell_addr(sel_row_r, sel_col_r);
            ram_we_nxt   = 1'b1;
            wr_pass_nxt  = 1'b1;
         end
         WR_A: begin
            state_nxt    = WR_B;
            ram_addr_nxt = cell_addr(tgt_row_r, tgt_col_r);
            ram_we_nxt   = 1'b1;
         end
         WR_B: begin
            state_nxt    = CHECK;
            ram_addr_nxt = 5'd0;
            cnt_nxt      = 5'd0;
            ok_nxt       = 1'b1;
            sel_row_nxt  = tgt_row_r;
            sel_col_nxt  = tgt_col_r;
            grabbed_nxt  = 1'b0;
            if (mc_r != MC_MAX) begin
               mc_nxt = mc_r + MC_ONE;
            end else begin
               mc_nxt = mc_r;
            end
         end
         CHECK: begin
            ok_nxt = ok_upd_s;
            if (cnt_r == SCAN_END) begin
               solved_nxt = ok_upd_s;
               state_nxt  = IDLE;
            end else begin
               cnt_nxt = cnt_r + 5'd1;
               if (cnt_r < LAST_ADDR) begin
                  ram_addr_nxt = cnt_r + 5'd1;
               end else begin
                  ram_addr_nxt = ram_addr_r;
               end
            end
         end
         default: begin
            state_nxt = INIT;
            cnt_nxt   = 5'd0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= INIT;
         cnt_r      <= 5'd0;
         ok_r       <= 1'b0;
         sel_row_r  <= 3'd2;
         sel_col_r  <= 3'd2;
         tgt_row_r  <= 3'd0;
         tgt_col_r  <= 3'd0;
         grabbed_r  <= 1'b0;
         ram_addr_r <= 5'd0;
         ram_we_r   <= 1'b0;
         wdata_r    <= 5'd0;
         wr_pass_r  <= 1'b0;
         busy_r     <= 1'b1;
         solved_r   <= 1'b0;
         mc_r       <= {MOVE_W{1'b0}};
      end else begin
         state_r    <= state_nxt;
         cnt_r      <= cnt_nxt;
         ok_r       <= ok_nxt;
         sel_row_r  <= sel_row_nxt;
         sel_col_r  <= sel_col_nxt;
         tgt_row_r  <= tgt_row_nxt;
         tgt_col_r  <= tgt_col_nxt;
         grabbed_r  <= grabbed_nxt;
         ram_addr_r <= ram_addr_nxt;
         ram_we_r   <= ram_we_nxt;
         wdata_r    <= wdata_nxt;
         wr_pass_r  <= wr_pass_nxt;
         busy_r     <= (state_nxt != IDLE);
         solved_r   <= solved_nxt;
         mc_r       <= mc_nxt;
      end
   end

   assign sel_row    = sel_row_r;
   assign sel_col    = sel_col_r;
   assign grabbed    = grabbed_r;
   assign ram_addr   = ram_addr_r;
   assign ram_we     = ram_we_r;
   assign ram_wdata  = wr_pass_r ? ram_rdata : wdata_r;
   assign busy       = busy_r;
   assign solved     = solved_r;
   assign move_count = mc_r;

endmodule
